// File: rtl/neo_pkg.sv
// -----------------------------------------------------------------------------
// neo_pkg
// Shared definitions for the NeoPixel frame sequencer: the four-state FSM
// encoding, strand geometry (8 pixels x 3 colour channels), index widths and
// a helper that decides whether a colour channel is selected.
// -----------------------------------------------------------------------------
package neo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } neo_state_e;

  localparam int NUM_PIXELS  = 8;
  localparam int NUM_COLORS  = 3;
  localparam int COLOR_IDX_W = 2;
  localparam int PIXEL_IDX_W = 3;
  localparam int LEVEL_W     = 8;
  localparam int SEL_W       = 2;

  localparam logic [COLOR_IDX_W-1:0] COLOR_LAST = COLOR_IDX_W'(NUM_COLORS - 1);
  localparam logic [PIXEL_IDX_W-1:0] PIXEL_LAST = PIXEL_IDX_W'(NUM_PIXELS - 1);

  // color_sel value that lights every channel of the head pixel
  localparam logic [SEL_W-1:0] SEL_ALL = SEL_W'(3);

  // True when channel 'color' is lit under selection 'sel'.
  function automatic logic channel_lit(input logic [SEL_W-1:0]       sel,
                                       input logic [COLOR_IDX_W-1:0] color);
    return (sel == SEL_ALL) || (sel == color);
  endfunction

endpackage

// File: rtl/neo_chase_pattern.sv
// -----------------------------------------------------------------------------
// neo_chase_pattern
// Purely combinational level generator for the chase animation. Only the
// head pixel is lit, and only on the selected channel(s).
//
// Ports:
//   head       in  PIXEL_IDX_W  current chase head pixel
//   pixel      in  PIXEL_IDX_W  pixel being addressed
//   color      in  COLOR_IDX_W  colour channel being addressed
//   color_sel  in  SEL_W        0..2 = single channel, 3 = all channels
//   brightness in  LEVEL_W      level for lit channels
//   level      out LEVEL_W      brightness when lit, else 0
// -----------------------------------------------------------------------------
module neo_chase_pattern
  import neo_pkg::*;
(
  input  logic [PIXEL_IDX_W-1:0] head,
  input  logic [PIXEL_IDX_W-1:0] pixel,
  input  logic [COLOR_IDX_W-1:0] color,
  input  logic [SEL_W-1:0]       color_sel,
  input  logic [LEVEL_W-1:0]     brightness,
  output logic [LEVEL_W-1:0]     level
);

  always_comb begin
    level = '0;
    if ((pixel == head) && channel_lit(color_sel, color)) begin
      level = brightness;
    end
  end

endmodule

// File: rtl/neo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neo_frame_sequencer
// Drives an 8-pixel RGB strand controller with a single-pixel chase. Each
// frame loads 24 levels (pixel-major, channel-minor), issues one send, waits
// FRAME_GAP_CYCLES idle cycles, then advances the chase head and repeats
// while enable is high. Clearing enable only stops at a frame boundary.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   enable         in   run frames continuously while high
//   brightness     in   [7:0] level for lit channels, captured at frame start
//   color_sel      in   [1:0] lit channel (0..2) or 3 = all, captured at frame start
//   ready_to_load  in   strand controller accepts load_color this cycle
//   ready_to_send  in   strand controller accepts send_it this cycle
//   pixel_index    out  [2:0] pixel being loaded
//   color_index    out  [1:0] channel being loaded (never 3)
//   color_level    out  [7:0] level for (pixel_index, color_index)
//   load_color     out  load strobe (LOAD state AND ready_to_load)
//   send_it        out  send strobe (SEND state AND ready_to_send)
//   busy           out  FSM not in IDLE
//   frame_count    out  [7:0] completed sends, wraps 255 -> 0
// -----------------------------------------------------------------------------
module neo_frame_sequencer
  import neo_pkg::*;
#(
  parameter int FRAME_GAP_CYCLES = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LEVEL_W-1:0]     brightness,
  input  logic [SEL_W-1:0]       color_sel,
  input  logic                   ready_to_load,
  input  logic                   ready_to_send,
  output logic [PIXEL_IDX_W-1:0] pixel_index,
  output logic [COLOR_IDX_W-1:0] color_index,
  output logic [LEVEL_W-1:0]     color_level,
  output logic                   load_color,
  output logic                   send_it,
  output logic                   busy,
  output logic [7:0]             frame_count
);

  localparam int GAP_W = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(FRAME_GAP_CYCLES - 1);

  neo_state_e             state_q, state_d;
  logic [PIXEL_IDX_W-1:0] pixel_q, pixel_d;
  logic [COLOR_IDX_W-1:0] color_q, color_d;
  logic [PIXEL_IDX_W-1:0] head_q, head_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [7:0]             frame_count_q, frame_count_d;
  logic [LEVEL_W-1:0]     bright_q, bright_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   busy_q, busy_d;

  logic load_fire;
  logic send_fire;
  logic start_frame;

  assign load_fire = (state_q == ST_LOAD) && ready_to_load;
  assign send_fire = (state_q == ST_SEND) && ready_to_send;

  always_comb begin
    state_d       = state_q;
    pixel_d       = pixel_q;
    color_d       = color_q;
    head_d        = head_q;
    gap_d         = gap_q;
    frame_count_d = frame_count_q;
    bright_d      = bright_q;
    sel_d         = sel_q;
    start_frame   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_frame = enable;
      end

      ST_LOAD: begin
        if (load_fire) begin
          if (color_q == COLOR_LAST) begin
            color_d = '0;
            // Pixel 7 wraps to 0, leaving the counters ready for the next frame.
            pixel_d = pixel_q + 1'b1;
            if (pixel_q == PIXEL_LAST) begin
              state_d = ST_SEND;
            end
          end else begin
            color_d = color_q + 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (send_fire) begin
          state_d       = ST_GAP;
          gap_d         = GAP_RELOAD;
          head_d        = head_q + 1'b1;
          frame_count_d = frame_count_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: capture the look of the whole frame so later input
    // changes cannot disturb a frame already in flight.
    if (start_frame) begin
      state_d  = ST_LOAD;
      bright_d = brightness;
      sel_d    = color_sel;
      pixel_d  = '0;
      color_d  = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // The level register is fed from next-state values so color_level lines up
  // with pixel_index/color_index in the same cycle.
  neo_chase_pattern u_pattern (
    .head       (head_d),
    .pixel      (pixel_d),
    .color      (color_d),
    .color_sel  (sel_d),
    .brightness (bright_d),
    .level      (level_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pixel_q       <= '0;
      color_q       <= '0;
      head_q        <= '0;
      gap_q         <= '0;
      frame_count_q <= '0;
      bright_q      <= '0;
      sel_q         <= '0;
      level_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_q       <= pixel_d;
      color_q       <= color_d;
      head_q        <= head_d;
      gap_q         <= gap_d;
      frame_count_q <= frame_count_d;
      bright_q      <= bright_d;
      sel_q         <= sel_d;
      level_q       <= level_d;
      busy_q        <= busy_d;
    end
  end

  assign pixel_index = pixel_q;
  assign color_index = color_q;
  assign color_level = level_q;
  assign load_color  = load_fire;
  assign send_it     = send_fire;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neo_frame_sequencer
// Scoreboard bench: the stimulus process pushes every expected load/send of a
// frame into a queue when it sets the frame up; an independent monitor pops
// and compares each time the DUT strobes load_color or send_it.
// -----------------------------------------------------------------------------
module tb_neo_frame_sequencer;

  localparam int GAP = 4;

  typedef struct {
    bit         is_send;
    logic [2:0] pixel;
    logic [1:0] color;
    logic [7:0] level;
  } exp_t;

  exp_t sb[$];

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'h00;
  logic [1:0] color_sel = 2'd0;
  logic       ready_to_load = 1'b1;
  logic       ready_to_send = 1'b1;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_color;
  logic       send_it;
  logic       busy;
  logic [7:0] frame_count;

  int checks = 0;
  int failures = 0;
  int loads_in_frame = 0;
  int last_frame_loads = 0;
  int hold_seen = 0;
  bit hold_check_en = 1'b0;
  bit toggle_on = 1'b0;
  logic [2:0] exp_head = 3'd0;

  neo_frame_sequencer #(.FRAME_GAP_CYCLES(GAP)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .brightness    (brightness),
    .color_sel     (color_sel),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .send_it       (send_it),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected sequence of one frame with the current model head.
  task automatic push_frame(input logic [7:0] b, input logic [1:0] s);
    exp_t e;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 3; c++) begin
        e.is_send = 1'b0;
        e.pixel   = 3'(p);
        e.color   = 2'(c);
        e.level   = ((3'(p) == exp_head) && ((s == 2'd3) || (s == 2'(c)))) ? b : 8'h00;
        sb.push_back(e);
      end
    end
    e.is_send = 1'b1;
    e.pixel   = 3'd0;
    e.color   = 2'd0;
    e.level   = 8'h00;
    sb.push_back(e);
    exp_head = exp_head + 3'd1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      sb.delete();
      loads_in_frame = 0;
    end else begin
      if (load_color && send_it) check("strobe_overlap", 1, 0);
      if (load_color) begin
        if (sb.size() == 0) begin
          check("load_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("load_kind", int'(e.is_send), 0);
          check("load_pixel", int'(pixel_index), int'(e.pixel));
          check("load_color_idx", int'(color_index), int'(e.color));
          check("load_level", int'(color_level), int'(e.level));
        end
        loads_in_frame++;
      end else if (send_it) begin
        if (sb.size() == 0) begin
          check("send_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("send_kind", int'(e.is_send), 1);
        end
        last_frame_loads = loads_in_frame;
        loads_in_frame = 0;
      end else if (hold_check_en && busy && !ready_to_load &&
                   loads_in_frame > 0 && loads_in_frame < 24 &&
                   sb.size() > 0 && !sb[0].is_send) begin
        // Stalled load: the presented item must still be the next expected one.
        hold_seen++;
        check("hold_pixel", int'(pixel_index), int'(sb[0].pixel));
        check("hold_color_idx", int'(color_index), int'(sb[0].color));
        check("hold_level", int'(color_level), int'(sb[0].level));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    exp_head = 3'd0;
  endtask

  task automatic wait_load(input string name, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!load_color && n < 200);
    if (!load_color) check({name, "_load_timeout"}, 1, 0);
  endtask

  task automatic wait_send(input string name, output bit ok);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!send_it && n < 200);
    ok = send_it;
    if (!ok) check({name, "_send_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 2000);
    if (busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    cycle();
    enable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, int'(pixel_index), 0);
    check({tag, "_color_idx"}, int'(color_index), 0);
    check({tag, "_level"}, int'(color_level), 0);
    check({tag, "_load_color"}, int'(load_color), 0);
    check({tag, "_send_it"}, int'(send_it), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int gapsum;
    int lit_n;
    int lit_p;
    int lit_c;
    int lit_l;
    int sends;
    bit ok;

    // Reset state
    reset = 1'b1;
    #12;
    check_all_zero("reset");
    cycle();
    reset = 1'b0;
    exp_head = 3'd0;

    // Test A: basic chase, color_sel=1, brightness 0x40, two frames
    brightness = 8'h40;
    color_sel  = 2'd1;
    push_frame(8'h40, 2'd1);
    push_frame(8'h40, 2'd1);
    enable = 1'b1;
    lit_n = 0; lit_p = -1; lit_c = -1; lit_l = -1; gapsum = 0;
    for (int i = 0; i < 24; i++) begin
      wait_load("a_f1", n);
      if (i > 0) gapsum += n;
      if (color_level != 8'h00) begin
        lit_n++; lit_p = pixel_index; lit_c = color_index; lit_l = color_level;
      end
    end
    check("a_consecutive_loads", gapsum, 23);
    check("a_lit_count", lit_n, 1);
    check("a_lit_pixel", lit_p, 0);
    check("a_lit_color", lit_c, 1);
    check("a_lit_level", lit_l, 8'h40);
    wait_send("a_f1", ok);
    wait_load("a_gap", n);
    check("a_gap_cycles", n - 1, 4);
    enable = 1'b0;
    lit_n = 0; lit_p = -1;
    if (color_level != 8'h00) begin lit_n++; lit_p = pixel_index; end
    for (int i = 1; i < 24; i++) begin
      wait_load("a_f2", n);
      if (color_level != 8'h00) begin lit_n++; lit_p = pixel_index; end
    end
    check("a_f2_lit_count", lit_n, 1);
    check("a_f2_lit_pixel", lit_p, 1);
    wait_idle("a");
    check("a_frame_count", int'(frame_count), 2);
    check("a_sb_empty", sb.size(), 0);

    // Test B: ready_to_load toggling, head 2, channel 0
    brightness = 8'h11;
    color_sel  = 2'd0;
    push_frame(8'h11, 2'd0);
    hold_seen = 0;
    hold_check_en = 1'b1;
    toggle_on = 1'b1;
    fork
      begin
        while (toggle_on) begin
          @(posedge clock);
          #1;
          ready_to_load = ~ready_to_load;
        end
      end
    join_none
    pulse_enable();
    wait_idle("b");
    toggle_on = 1'b0;
    repeat (2) cycle();
    ready_to_load = 1'b1;
    hold_check_en = 1'b0;
    check("b_loads_per_frame", last_frame_loads, 24);
    check("b_hold_observed", int'(hold_seen >= 10), 1);
    check("b_frame_count", int'(frame_count), 3);
    check("b_sb_empty", sb.size(), 0);

    // Test C: ready_to_send held low 20 cycles after the last load
    brightness = 8'h22;
    color_sel  = 2'd2;
    push_frame(8'h22, 2'd2);
    ready_to_send = 1'b0;
    pulse_enable();
    for (int i = 0; i < 24; i++) wait_load("c", n);
    lit_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (send_it || !busy) lit_n++;
    end
    check("c_stall_bad_cycles", lit_n, 0);
    check("c_busy_stalled", int'(busy), 1);
    @(posedge clock);
    #1;
    ready_to_send = 1'b1;
    @(negedge clock);
    check("c_send_on_ready", int'(send_it), 1);
    @(negedge clock);
    check("c_send_single", int'(send_it), 0);
    wait_idle("c");
    check("c_frame_count", int'(frame_count), 4);
    check("c_sb_empty", sb.size(), 0);

    // Test D: enable dropped at load #10
    do_reset();
    brightness = 8'h80;
    color_sel  = 2'd2;
    push_frame(8'h80, 2'd2);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) wait_load("d", n);
    enable = 1'b0;
    wait_idle("d");
    check("d_busy", int'(busy), 0);
    check("d_frame_count", int'(frame_count), 1);
    check("d_loads_per_frame", last_frame_loads, 24);
    repeat (10) cycle();
    check("d_stays_idle", int'(busy), 0);
    check("d_sb_empty", sb.size(), 0);

    // Test E: all channels, head wrap, 256 frames wrap frame_count
    do_reset();
    brightness = 8'h5A;
    color_sel  = 2'd3;
    for (int f = 0; f < 256; f++) push_frame(8'h5A, 2'd3);
    enable = 1'b1;
    sends = 0;
    ok = 1'b1;
    while (sends < 256 && ok) begin
      wait_send("e", ok);
      if (ok) begin
        sends++;
        if (sends == 8) begin
          // frame 9: head has wrapped back to pixel 0, all three channels lit
          for (int c = 0; c < 3; c++) begin
            wait_load("e_f9", n);
            check("e_f9_pixel", int'(pixel_index), 0);
            check("e_f9_level", int'(color_level), 8'h5A);
          end
        end
        if (sends == 9) begin
          @(negedge clock);
          check("e_frame_count_9", int'(frame_count), 9);
        end
        if (sends == 255) begin
          wait_load("e_last", n);
          enable = 1'b0;
        end
      end
    end
    check("e_sends", sends, 256);
    wait_idle("e");
    check("e_frame_count_wrap", int'(frame_count), 0);
    check("e_sb_empty", sb.size(), 0);

    // Test F: asynchronous reset at load #5
    brightness = 8'h33;
    color_sel  = 2'd0;
    push_frame(8'h33, 2'd0);
    pulse_enable();
    for (int i = 0; i < 5; i++) wait_load("f", n);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("f_async");
    repeat (2) cycle();
    reset = 1'b0;
    exp_head = 3'd0;
    check("f_sb_flushed", sb.size(), 0);
    push_frame(8'h33, 2'd0);
    pulse_enable();
    wait_load("f_restart", n);
    check("f_first_pixel", int'(pixel_index), 0);
    check("f_first_color", int'(color_index), 0);
    check("f_first_level", int'(color_level), 8'h33);
    wait_idle("f");
    check("f_frame_count", int'(frame_count), 1);
    check("f_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
